// File: rtl/rv_pkg.sv
// Shared types for the multicycle sequencing core: stage states, opcode
// constants, trap causes and the opcode classifier.
package rv_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_IMEM_TO = 2'd2,
        CAUSE_DMEM_TO = 2'd3
    } cause_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic op_class_t op_class(input logic [6:0] opcode);
        op_class_t cls;
        case (opcode)
            OP_R, OP_I: cls = CLS_ALU;
            OP_LOAD:    cls = CLS_LOAD;
            OP_STORE:   cls = CLS_STORE;
            OP_BRANCH:  cls = CLS_BRANCH;
            OP_JAL:     cls = CLS_JAL;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter shared by instruction and data accesses; o_expired flags
// the last cycle a request may still be acknowledged.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic srst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (srst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Count k means k cycles have already gone unacknowledged.
    assign o_expired = (r_count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Stage sequencer for the multicycle RISC-V datapath: owns PC, IR, retired
// count and trap state, and drives memory handshakes and stage enables.
module multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 15,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    output logic [31:0]      ir,
    output logic [XLEN-1:0]  pc,
    output logic             ex_en,
    output logic             rf_we,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    state_t           r_state;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_jal_target;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_instret;
    logic             r_trap;
    cause_t           r_cause;

    op_class_t        w_cls;
    logic [XLEN-1:0]  w_pc_plus4;
    logic             w_waiting;
    logic             w_ack;
    logic             w_expired;

    assign w_cls      = op_class(r_ir[6:0]);
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_waiting  = (r_state == FETCH) || (r_state == MEM);
    assign w_ack      = ((r_state == FETCH) && imem_ack) || ((r_state == MEM) && dmem_ack);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .srst      (reset),
        .i_clear   (w_ack || w_expired || !w_waiting),
        .i_en      (w_waiting),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_jal_target <= '0;
            r_ir         <= '0;
            r_instret    <= '0;
            r_trap       <= 1'b0;
            r_cause      <= CAUSE_NONE;
        end else begin
            case (r_state)
                FETCH: begin
                    // An ack on the final wait cycle still wins over the timeout.
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_state <= DECODE;
                    end else if (w_expired) begin
                        r_state <= TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= CAUSE_IMEM_TO;
                    end
                end
                DECODE: begin
                    if (w_cls == CLS_ILLEGAL) begin
                        r_state <= TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= CAUSE_ILLEGAL;
                    end else begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    case (w_cls)
                        CLS_BRANCH: begin
                            r_pc      <= br_taken ? br_target : w_pc_plus4;
                            r_instret <= r_instret + CNT_W'(1);
                            r_state   <= FETCH;
                        end
                        CLS_LOAD, CLS_STORE: r_state <= MEM;
                        CLS_JAL: begin
                            r_jal_target <= br_target;
                            r_state      <= WB;
                        end
                        default: r_state <= WB;
                    endcase
                end
                MEM: begin
                    if (dmem_ack) begin
                        if (w_cls == CLS_STORE) begin
                            r_pc      <= w_pc_plus4;
                            r_instret <= r_instret + CNT_W'(1);
                            r_state   <= FETCH;
                        end else begin
                            r_state <= WB;
                        end
                    end else if (w_expired) begin
                        r_state <= TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= CAUSE_DMEM_TO;
                    end
                end
                WB: begin
                    r_pc      <= (w_cls == CLS_JAL) ? r_jal_target : w_pc_plus4;
                    r_instret <= r_instret + CNT_W'(1);
                    r_state   <= FETCH;
                end
                default: begin
                    // TRAP is absorbing until reset.
                end
            endcase
        end
    end

    assign imem_req   = (r_state == FETCH);
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == MEM);
    assign dmem_we    = (r_state == MEM) && (w_cls == CLS_STORE);
    assign ex_en      = (r_state == EXEC);
    assign rf_we      = (r_state == WB);
    assign mem_to_reg = (r_state == WB) && (w_cls == CLS_LOAD);
    assign ir         = r_ir;
    assign pc         = r_pc;
    assign instret    = r_instret;
    assign trap       = r_trap;
    assign trap_cause = r_cause;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level timeline model
// predicts every cycle's outputs, plus literal checkpoints on PC/instret/trap.
module tb_multicycle_ctrl;

    localparam int          XLEN        = 32;
    localparam int          CNT_W       = 32;
    localparam int          MEM_TIMEOUT = 15;
    localparam logic [31:0] RESET_PC    = 32'h0;

    localparam logic [31:0] JUNK_INSN = 32'hFFFF_FFFF;
    localparam logic [31:0] JUNK_TGT  = 32'hDEAD_BEEC;

    // flag order: {imem_req, dmem_req, dmem_we, ex_en, rf_we, mem_to_reg}
    localparam logic [5:0] F_NONE   = 6'b000000;
    localparam logic [5:0] F_FETCH  = 6'b100000;
    localparam logic [5:0] F_MEM_LD = 6'b010000;
    localparam logic [5:0] F_MEM_ST = 6'b011000;
    localparam logic [5:0] F_EX     = 6'b000100;
    localparam logic [5:0] F_WB     = 6'b000010;
    localparam logic [5:0] F_WB_LD  = 6'b000011;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_JAL = 4, K_ILL = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             br_taken;
    logic [XLEN-1:0]  br_target;
    logic [31:0]      ir;
    logic [XLEN-1:0]  pc;
    logic             ex_en;
    logic             rf_we;
    logic             mem_to_reg;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .XLEN        (XLEN),
        .RESET_PC    (RESET_PC),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .ir         (ir),
        .pc         (pc),
        .ex_en      (ex_en),
        .rf_we      (rf_we),
        .mem_to_reg (mem_to_reg),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    int n_cmp = 0;
    int n_err = 0;

    // architectural model state
    logic [31:0]      m_pc, m_ir, m_jal;
    logic [CNT_W-1:0] m_instret;
    logic             m_trap;
    logic [1:0]       m_cause;

    // expected outputs for the current cycle
    logic             e_valid = 1'b0;
    logic [5:0]       e_flags;
    logic [31:0]      e_pc, e_ir;
    logic [CNT_W-1:0] e_instret;
    logic             e_trap;
    logic [1:0]       e_cause;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (e_valid) begin
            chk("imem_req",   imem_req,   e_flags[5]);
            chk("dmem_req",   dmem_req,   e_flags[4]);
            if (e_flags[4]) chk("dmem_we", dmem_we, e_flags[3]);
            chk("ex_en",      ex_en,      e_flags[2]);
            chk("rf_we",      rf_we,      e_flags[1]);
            chk("mem_to_reg", mem_to_reg, e_flags[0]);
            chk("imem_addr",  imem_addr,  e_pc);
            chk("pc",         pc,         e_pc);
            chk("ir",         ir,         e_ir);
            chk("instret",    instret,    e_instret);
            chk("trap",       trap,       e_trap);
            chk("trap_cause", trap_cause, e_cause);
        end
    end

    function automatic int kind_of(input logic [31:0] insn);
        int k;
        case (insn[6:0])
            7'b0110011, 7'b0010011: k = K_ALU;
            7'b0000011:             k = K_LOAD;
            7'b0100011:             k = K_STORE;
            7'b1100011:             k = K_BRANCH;
            7'b1101111:             k = K_JAL;
            default:                k = K_ILL;
        endcase
        return k;
    endfunction

    // One clock cycle: drive inputs for the coming edge and publish expectations.
    task automatic cyc(input logic [5:0] f, input logic iack, input logic [31:0] rdata,
                       input logic dack, input logic tk, input logic [31:0] tgt);
        imem_ack   = iack;
        imem_rdata = rdata;
        dmem_ack   = dack;
        br_taken   = tk;
        br_target  = tgt;
        e_flags    = f;
        e_pc       = m_pc;
        e_ir       = m_ir;
        e_instret  = m_instret;
        e_trap     = m_trap;
        e_cause    = m_cause;
        e_valid    = 1'b1;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_ir      = '0;
        m_jal     = '0;
        m_instret = '0;
        m_trap    = 1'b0;
        m_cause   = 2'd0;
    endtask

    task automatic do_reset();
        e_valid  = 1'b0;
        reset    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(F_NONE, 1'b1, 32'h0000_0013, 1'b1, 1'b1, JUNK_TGT);
    endtask

    // Plays one instruction: iwait/dwait = unacked cycles before the ack,
    // rst_at = MEM cycle in which reset is asserted (-1 for none).
    task automatic run_instr(input logic [31:0] insn, input int iwait, input int dwait,
                             input logic tk, input logic [31:0] tgt, input int rst_at);
        int k = kind_of(insn);
        for (int c = 0; c < MEM_TIMEOUT; c++) begin
            if (c == iwait) begin
                cyc(F_FETCH, 1'b1, insn, 1'b1, 1'b0, JUNK_TGT);
                m_ir = insn;
                break;
            end
            cyc(F_FETCH, 1'b0, JUNK_INSN, 1'b1, 1'b0, JUNK_TGT);
        end
        if (iwait >= MEM_TIMEOUT) begin
            m_trap  = 1'b1;
            m_cause = 2'd2;
            return;
        end
        cyc(F_NONE, 1'b1, JUNK_INSN, 1'b1, 1'b1, JUNK_TGT);
        if (k == K_ILL) begin
            m_trap  = 1'b1;
            m_cause = 2'd1;
            return;
        end
        cyc(F_EX, 1'b1, JUNK_INSN, 1'b1, tk, tgt);
        if (k == K_BRANCH) begin
            m_pc      = tk ? tgt : m_pc + 32'd4;
            m_instret = m_instret + 1;
            return;
        end
        if (k == K_JAL) m_jal = tgt;
        if (k == K_LOAD || k == K_STORE) begin
            for (int c = 0; c < MEM_TIMEOUT; c++) begin
                if (c == rst_at) begin
                    reset = 1'b1;
                    cyc((k == K_STORE) ? F_MEM_ST : F_MEM_LD, 1'b1, JUNK_INSN, 1'b0, 1'b1, JUNK_TGT);
                    reset = 1'b0;
                    model_reset();
                    return;
                end
                if (c == dwait) begin
                    cyc((k == K_STORE) ? F_MEM_ST : F_MEM_LD, 1'b1, JUNK_INSN, 1'b1, 1'b1, JUNK_TGT);
                    break;
                end
                cyc((k == K_STORE) ? F_MEM_ST : F_MEM_LD, 1'b1, JUNK_INSN, 1'b0, 1'b1, JUNK_TGT);
            end
            if (dwait >= MEM_TIMEOUT) begin
                m_trap  = 1'b1;
                m_cause = 2'd3;
                return;
            end
            if (k == K_STORE) begin
                m_pc      = m_pc + 32'd4;
                m_instret = m_instret + 1;
                return;
            end
        end
        // br_target is deliberately garbage here so a JAL must use its latched target
        cyc((k == K_LOAD) ? F_WB_LD : F_WB, 1'b1, JUNK_INSN, 1'b1, 1'b1, JUNK_TGT);
        m_pc      = (k == K_JAL) ? m_jal : m_pc + 32'd4;
        m_instret = m_instret + 1;
    endtask

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] LW   = 32'h0000_A103;
    localparam logic [31:0] SW   = 32'h0020_A223;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] JAL  = 32'h0000_006F;

    initial begin
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dmem_ack   = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("reset_pc", pc, 32'h0);
        chk("reset_ir", ir, 32'h0);
        chk("reset_instret", instret, 0);
        chk("reset_dmem_req", dmem_req, 1'b0);

        run_instr(ADDI, 0, 0, 1'b0, JUNK_TGT, -1);
        chk("addi_pc", pc, 32'h4);
        chk("addi_instret", instret, 1);

        run_instr(LW, 2, 3, 1'b0, JUNK_TGT, -1);
        chk("lw_pc", pc, 32'h8);
        chk("lw_instret", instret, 2);

        run_instr(SW, 0, 0, 1'b0, JUNK_TGT, -1);
        chk("sw_pc", pc, 32'hC);

        run_instr(BEQ, 0, 0, 1'b1, 32'h40, -1);
        chk("beq_taken_pc", pc, 32'h40);
        run_instr(BEQ, 1, 0, 1'b0, 32'h80, -1);
        chk("beq_not_taken_pc", pc, 32'h44);
        chk("beq_instret", instret, 5);

        run_instr(JAL, 0, 0, 1'b0, 32'hFFFF_FFFC, -1);
        chk("jal_pc", pc, 32'hFFFF_FFFC);
        run_instr(ADDI, 0, 0, 1'b0, JUNK_TGT, -1);
        chk("pc_wrap", pc, 32'h0);

        run_instr(ADDI, MEM_TIMEOUT - 1, 0, 1'b0, JUNK_TGT, -1);
        chk("late_ack_trap", trap, 1'b0);
        chk("late_ack_pc", pc, 32'h4);

        run_instr(32'hFFFF_FFFF, 0, 0, 1'b0, JUNK_TGT, -1);
        idle(20);
        chk("ill_trap", trap, 1'b1);
        chk("ill_cause", trap_cause, 2'd1);
        chk("ill_pc", pc, 32'h4);
        chk("ill_instret", instret, 8);

        do_reset();
        chk("post_trap_pc", pc, 32'h0);
        chk("post_trap_trap", trap, 1'b0);
        run_instr(ADDI, MEM_TIMEOUT, 0, 1'b0, JUNK_TGT, -1);
        idle(5);
        chk("imem_to_cause", trap_cause, 2'd2);

        do_reset();
        run_instr(LW, 0, MEM_TIMEOUT + 5, 1'b0, JUNK_TGT, -1);
        idle(3);
        chk("dmem_to_cause", trap_cause, 2'd3);
        chk("dmem_to_pc", pc, 32'h0);

        do_reset();
        run_instr(ADDI, 0, 0, 1'b0, JUNK_TGT, -1);
        run_instr(LW, 0, 6, 1'b0, JUNK_TGT, 2);
        chk("midmem_rst_pc", pc, 32'h0);
        chk("midmem_rst_instret", instret, 0);
        chk("midmem_rst_dmem_req", dmem_req, 1'b0);
        chk("midmem_rst_imem_req", imem_req, 1'b1);
        run_instr(ADDI, 0, 0, 1'b0, JUNK_TGT, -1);
        chk("after_rst_pc", pc, 32'h4);

        e_valid = 1'b0;
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
